// File: rtl/alu_pipe.sv
// Pipelined MIPS-funct ALU with valid/ready handshake on both sides and status flags.
// Optional feature macro: ALU_PIPE_SATURATE_EN (clamp ADD/SUB results on signed overflow).
module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OP     = 6,
    parameter int NB_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_DATA-1:0]   i_data_a,
    input  logic [NB_DATA-1:0]   i_data_b,
    input  logic [NB_OP-1:0]     i_operation,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_zero,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_err
);

    localparam int SHW  = $clog2(NB_DATA);
    localparam int MSB  = NB_DATA - 1;
    localparam int LAST = NB_STAGES - 1;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    localparam logic [NB_DATA-1:0] SAT_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic [NB_DATA-1:0] SAT_MIN = {1'b1, {(NB_DATA-1){1'b0}}};

    logic [NB_DATA:0]   sum_s;
    logic [NB_DATA:0]   dif_s;
    logic [SHW-1:0]     shamt_s;
    logic [NB_DATA-1:0] res_s;
    logic [NB_DATA-1:0] fin_s;
    logic               carry_s;
    logic               ovf_s;
    logic               err_s;
    logic               zero_s;

    // Per-stage storage: flags packed as {zero, carry, overflow, err}
    logic               vld_r [NB_STAGES];
    logic [NB_DATA-1:0] res_r [NB_STAGES];
    logic [3:0]         flg_r [NB_STAGES];
    logic [NB_STAGES-1:0] rdy_s;

    // Operation decode and flag generation for the operands being offered this cycle
    always_comb begin
        sum_s   = {1'b0, i_data_a} + {1'b0, i_data_b};
        dif_s   = {1'b0, i_data_a} - {1'b0, i_data_b};
        shamt_s = i_data_b[SHW-1:0];
        res_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (i_operation)
            OP_ADD: begin
                res_s   = sum_s[NB_DATA-1:0];
                carry_s = sum_s[NB_DATA];
                ovf_s   = (i_data_a[MSB] == i_data_b[MSB]) && (sum_s[MSB] != i_data_a[MSB]);
            end
            OP_SUB: begin
                res_s   = dif_s[NB_DATA-1:0];
                carry_s = dif_s[NB_DATA];
                ovf_s   = (i_data_a[MSB] != i_data_b[MSB]) && (dif_s[MSB] != i_data_a[MSB]);
            end
            OP_AND: res_s = i_data_a & i_data_b;
            OP_OR:  res_s = i_data_a | i_data_b;
            OP_XOR: res_s = i_data_a ^ i_data_b;
            OP_NOR: res_s = ~(i_data_a | i_data_b);
            OP_SRA: res_s = $unsigned($signed(i_data_a) >>> shamt_s);
            OP_SRL: res_s = i_data_a >> shamt_s;
            default: err_s = 1'b1;
        endcase
`ifdef ALU_PIPE_SATURATE_EN
        // Overflow direction follows the sign of A: positive A can only overflow upward
        fin_s = ovf_s ? (i_data_a[MSB] ? SAT_MIN : SAT_MAX) : res_s;
`else
        fin_s = res_s;
`endif
        zero_s = (fin_s == '0);
    end

    // A stage can take new data when the output drains or any stage at or after it is empty
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        rdy_s    = '0;
        for (int k = LAST; k >= 0; k--) begin
            all_full = all_full & vld_r[k];
            rdy_s[k] = i_ready | ~all_full;
        end
    end

    assign o_ready = rdy_s[0];

    for (genvar k = 0; k < NB_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // First stage captures the freshly computed result on an input transfer
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_r[0] <= 1'b0;
                    res_r[0] <= '0;
                    flg_r[0] <= 4'b0000;
                end else if (rdy_s[0]) begin
                    vld_r[0] <= i_valid;
                    if (i_valid) begin
                        res_r[0] <= fin_s;
                        flg_r[0] <= {zero_s, carry_s, ovf_s, err_s};
                    end
                end
            end
        end else begin : g_next
            // Later stages pull from their predecessor whenever they have room
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_r[k] <= 1'b0;
                    res_r[k] <= '0;
                    flg_r[k] <= 4'b0000;
                end else if (rdy_s[k]) begin
                    vld_r[k] <= vld_r[k-1];
                    if (vld_r[k-1]) begin
                        res_r[k] <= res_r[k-1];
                        flg_r[k] <= flg_r[k-1];
                    end
                end
            end
        end
    end

    assign o_valid    = vld_r[LAST];
    assign o_result   = res_r[LAST];
    assign o_zero     = flg_r[LAST][3];
    assign o_carry    = flg_r[LAST][2];
    assign o_overflow = flg_r[LAST][1];
    assign o_err      = flg_r[LAST][0];

endmodule
